// File: rtl/vga_frame_compositor_if.sv
// Object-controller bus: raster request fanned out to every layer, registered colour replies back.
// The compositor is the master; each layer controller sits on the slave side.
interface vga_frame_compositor_if #(
  parameter int N_LAYERS = 4
);
  logic [10:0]               requested_x;
  logic [10:0]               requested_y;
  logic                      frame_start;
  logic [N_LAYERS-1:0][7:0]  layer_colors;

  modport master (output requested_x, output requested_y, output frame_start, input layer_colors);
  modport slave  (input requested_x, input requested_y, input frame_start, output layer_colors);
endinterface

// File: rtl/vga_frame_compositor.sv
// VGA raster scan, fixed-priority layer compositing and per-frame player-overlap report.
// Pixel requested at cycle t reaches the DAC at t+LAYER_LATENCY+1; free-running, no backpressure.
module vga_frame_compositor #(
  parameter int         H_ACTIVE      = 640,
  parameter int         H_FP          = 16,
  parameter int         H_SYNC        = 96,
  parameter int         H_BP          = 48,
  parameter int         V_ACTIVE      = 480,
  parameter int         V_FP          = 10,
  parameter int         V_SYNC        = 2,
  parameter int         V_BP          = 33,
  parameter int         N_LAYERS      = 4,
  parameter int         LAYER_LATENCY = 2,
  parameter logic [7:0] MASK_VALUE    = 8'h62,
  parameter logic [7:0] BG_COLOR      = 8'h00
) (
  input  logic                    clk,
  input  logic                    resetN,
  vga_frame_compositor_if.master  obj_if,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    vga_hsync_n,
  output logic                    vga_vsync_n,
  output logic                    vga_blank_n,
  output logic [N_LAYERS-1:0]     frame_overlap
);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [N_LAYERS-1:0] PLAYER_BIT = N_LAYERS'(1);

  logic [10:0]              r_h, r_v;
  logic [LAYER_LATENCY-1:0] r_act_d, r_hs_d, r_vs_d;
  logic [7:0]               r_color;
  logic                     r_hsync_n, r_vsync_n, r_blank_n;
  logic [N_LAYERS-1:0]      r_acc, r_frame_overlap;

  logic                     w_active, w_hs, w_vs, w_frame_start, w_act_dly;
  logic [N_LAYERS-1:0]      w_opaque;
  logic [7:0]               w_color;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 11'd1;
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  assign obj_if.requested_x = r_h;
  assign obj_if.requested_y = r_v;
  // Start of vertical blanking, so controllers move their objects off-screen.
  assign w_frame_start      = (r_h == '0) && (r_v == V_ACT);
  assign obj_if.frame_start = w_frame_start;

  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs     = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
  assign w_vs     = (r_v >= VS_FIRST) && (r_v <= VS_LAST);

  // Raster flags travel alongside the controllers' reply latency.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_act_d <= '0;
      r_hs_d  <= '0;
      r_vs_d  <= '0;
    end else begin
      r_act_d[0] <= w_active;
      r_hs_d[0]  <= w_hs;
      r_vs_d[0]  <= w_vs;
      for (int i = 1; i < LAYER_LATENCY; i++) begin
        r_act_d[i] <= r_act_d[i-1];
        r_hs_d[i]  <= r_hs_d[i-1];
        r_vs_d[i]  <= r_vs_d[i-1];
      end
    end
  end

  assign w_act_dly = r_act_d[LAYER_LATENCY-1];

  always_comb begin
    w_opaque = '0;
    for (int k = 0; k < N_LAYERS; k++)
      w_opaque[k] = (obj_if.layer_colors[k] != MASK_VALUE);
  end

  // Walk from lowest to highest priority so layer 0 overrides everything.
  always_comb begin
    w_color = BG_COLOR;
    for (int k = N_LAYERS - 1; k >= 0; k--)
      if (w_opaque[k]) w_color = obj_if.layer_colors[k];
    if (!w_act_dly) w_color = 8'h00;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_color   <= 8'h00;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_color   <= w_color;
      r_hsync_n <= ~r_hs_d[LAYER_LATENCY-1];
      r_vsync_n <= ~r_vs_d[LAYER_LATENCY-1];
      r_blank_n <= w_act_dly;
    end
  end

  // Clear takes precedence over accumulate on the frame boundary.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc           <= '0;
      r_frame_overlap <= '0;
    end else if (w_frame_start) begin
      r_frame_overlap <= r_acc;
      r_acc           <= '0;
    end else if (w_act_dly && w_opaque[0]) begin
      r_acc <= r_acc | (w_opaque & ~PLAYER_BIT);
    end
  end

  assign vga_r         = {r_color[7:5], r_color[7:5], r_color[7:6]};
  assign vga_g         = {r_color[4:2], r_color[4:2], r_color[4:3]};
  assign vga_b         = {r_color[1:0], r_color[1:0], r_color[1:0], r_color[1:0]};
  assign vga_hsync_n   = r_hsync_n;
  assign vga_vsync_n   = r_vsync_n;
  assign vga_blank_n   = r_blank_n;
  assign frame_overlap = r_frame_overlap;
endmodule

// File: tb/tb_vga_frame_compositor.sv
// Directed bench on a shrunken 24x18 raster (16x12 visible) with rectangle-drawing layer models.
module tb_vga_frame_compositor;
  localparam int H_ACT = 16, H_FP = 2, H_SY = 3, H_BP = 3, HT = 24;
  localparam int V_ACT = 12, V_FP = 2, V_SY = 2, V_BP = 2, VT = 18;
  localparam int FRAME = HT * VT;
  localparam logic [7:0] MASK = 8'h62;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hsync_n, vga_vsync_n, vga_blank_n;
  logic [3:0] frame_overlap;
  int         n_tests = 0;
  int         n_fail = 0;

  vga_frame_compositor_if #(.N_LAYERS(4)) bus ();

  vga_frame_compositor #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .N_LAYERS(4), .LAYER_LATENCY(2), .MASK_VALUE(8'h62), .BG_COLOR(8'h00)
  ) dut (
    .clk(clk), .resetN(resetN), .obj_if(bus),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync_n(vga_hsync_n), .vga_vsync_n(vga_vsync_n), .vga_blank_n(vga_blank_n),
    .frame_overlap(frame_overlap)
  );

  always #5 clk = ~clk;

  // Layer controllers: each draws one rectangle, reply registered twice.
  int               rx0[4], rx1[4], ry0[4], ry1[4];
  logic [7:0]       rcol[4];
  logic [3:0][7:0]  col_p1, col_p2;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      col_p1[k] <= (int'(bus.requested_x) >= rx0[k] && int'(bus.requested_x) <= rx1[k] &&
                    int'(bus.requested_y) >= ry0[k] && int'(bus.requested_y) <= ry1[k]) ? rcol[k] : MASK;
    col_p2 <= col_p1;
  end
  assign bus.layer_colors = col_p2;

  task automatic set_rect(input int k, input int x0, input int x1, input int y0, input int y1,
                          input logic [7:0] c);
    rx0[k] = x0; rx1[k] = x1; ry0[k] = y0; ry1[k] = y1; rcol[k] = c;
  endtask

  task automatic clear_rects();
    for (int k = 0; k < 4; k++) set_rect(k, 1, 0, 1, 0, MASK);
  endtask

  task automatic wait_xy(input int x, input int y);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk); #1;
      if (bus.requested_x == 11'(x) && bus.requested_y == 11'(y)) found = 1'b1;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL wait_xy: pixel (%0d,%0d) not reached within %0d cycles", x, y, 2 * FRAME);
    end
  endtask

  task automatic wait_fs();
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(posedge clk); #1;
      if (bus.frame_start === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL wait_fs: no frame_start within %0d cycles", 2 * FRAME);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.requested_x !== 11'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", bus.requested_x); end
    n_tests++; if (bus.requested_y !== 11'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", bus.requested_y); end
    n_tests++; if (bus.frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", bus.frame_start); end
    n_tests++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb: got %h want 000000", {vga_r, vga_g, vga_b}); end
    n_tests++; if ({vga_hsync_n, vga_vsync_n, vga_blank_n} !== 3'b110) begin n_fail++; $display("FAIL reset_sync: got %b want 110", {vga_hsync_n, vga_vsync_n, vga_blank_n}); end
    n_tests++; if (frame_overlap !== 4'b0000) begin n_fail++; $display("FAIL reset_overlap: got %b want 0000", frame_overlap); end
  endtask

  task automatic test_raster();
    int ex = 0, ey = 0, nfs = 0, first_fs = -1, last_fs = -1, period = 0;
    int e_x = 0, e_y = 0, e_fs = 0, e_sync = 0, e_rgb = 0;
    int hs_low = 0, vs_low = 0, bl_hi = 0, t_x18 = -1, t_hs = -1, t_vs = -1;
    logic [2:0] d1 = 3'b110, d2 = 3'b110, d3 = 3'b110, f;
    resetN = 1'b1;
    for (int t = 0; t < 2 * FRAME; t++) begin
      if (t != 0) begin
        @(posedge clk); #1;
        ex++;
        if (ex == HT) begin ex = 0; ey = (ey == VT - 1) ? 0 : ey + 1; end
      end
      if (bus.requested_x !== 11'(ex)) e_x++;
      if (bus.requested_y !== 11'(ey)) e_y++;
      if (bus.frame_start !== 1'(ex == 0 && ey == V_ACT)) e_fs++;
      if (bus.frame_start === 1'b1) begin
        nfs++;
        if (first_fs < 0) first_fs = t;
        if (last_fs >= 0) period = t - last_fs;
        last_fs = t;
      end
      if ({vga_hsync_n, vga_vsync_n, vga_blank_n} !== d3) e_sync++;
      if ({vga_r, vga_g, vga_b} !== 24'h0) e_rgb++;
      if (vga_hsync_n === 1'b0) hs_low++;
      if (vga_vsync_n === 1'b0) vs_low++;
      if (vga_blank_n === 1'b1) bl_hi++;
      if (t_x18 < 0 && bus.requested_x == 11'(H_ACT + H_FP)) t_x18 = t;
      if (t_hs < 0 && vga_hsync_n === 1'b0) t_hs = t;
      if (t_vs < 0 && vga_vsync_n === 1'b0) t_vs = t;
      f[2] = !(ex >= H_ACT + H_FP && ex < H_ACT + H_FP + H_SY);
      f[1] = !(ey >= V_ACT + V_FP && ey < V_ACT + V_FP + V_SY);
      f[0] = (ex < H_ACT && ey < V_ACT);
      d3 = d2; d2 = d1; d1 = f;
    end
    n_tests++; if (e_x != 0) begin n_fail++; $display("FAIL raster_x: %0d cycles off, want 0", e_x); end
    n_tests++; if (e_y != 0) begin n_fail++; $display("FAIL raster_y: %0d cycles off, want 0", e_y); end
    n_tests++; if (e_fs != 0) begin n_fail++; $display("FAIL raster_fs: %0d cycles off, want 0", e_fs); end
    n_tests++; if (nfs != 2) begin n_fail++; $display("FAIL fs_count: got %0d want 2", nfs); end
    n_tests++; if (first_fs != V_ACT * HT) begin n_fail++; $display("FAIL fs_first: got %0d want %0d", first_fs, V_ACT * HT); end
    n_tests++; if (period != FRAME) begin n_fail++; $display("FAIL fs_period: got %0d want %0d", period, FRAME); end
    n_tests++; if (e_sync != 0) begin n_fail++; $display("FAIL sync_align: %0d cycles off, want 0", e_sync); end
    n_tests++; if (e_rgb != 0) begin n_fail++; $display("FAIL bg_rgb: %0d cycles nonzero, want 0", e_rgb); end
    n_tests++; if (hs_low != 2 * VT * H_SY) begin n_fail++; $display("FAIL hs_low: got %0d want %0d", hs_low, 2 * VT * H_SY); end
    n_tests++; if (vs_low != 2 * V_SY * HT) begin n_fail++; $display("FAIL vs_low: got %0d want %0d", vs_low, 2 * V_SY * HT); end
    n_tests++; if (bl_hi != 2 * H_ACT * V_ACT) begin n_fail++; $display("FAIL blank_hi: got %0d want %0d", bl_hi, 2 * H_ACT * V_ACT); end
    n_tests++; if (t_hs - t_x18 != 3) begin n_fail++; $display("FAIL hs_delay: got %0d want 3", t_hs - t_x18); end
    n_tests++; if (t_vs != (V_ACT + V_FP) * HT + 3) begin n_fail++; $display("FAIL vs_start: got %0d want %0d", t_vs, (V_ACT + V_FP) * HT + 3); end
  endtask

  // Layer colours packed {l0,l1,l2,l3} and the expected {r,g,b}.
  logic [31:0] p_in  [6] = '{32'h62E01C03, 32'h62626262, 32'hFFE01C03, 32'h62621C03, 32'hB6E01C03, 32'h62626203};
  logic [23:0] p_exp [6] = '{24'hFF0000,   24'h000000,   24'hFFFFFF,   24'h00FF00,   24'hB6B6AA,   24'h0000FF};

  task automatic test_priority();
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) set_rect(k, 0, HT - 1, 0, VT - 1, p_in[i][8 * (3 - k) +: 8]);
      repeat (3) @(posedge clk);
      wait_xy(5, 2 + i);
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({vga_r, vga_g, vga_b, vga_blank_n} !== {p_exp[i], 1'b1}) begin
        n_fail++;
        $display("FAIL priority_%0d: layers %h got rgb=%h blank=%b want rgb=%h blank=1",
                 i, p_in[i], {vga_r, vga_g, vga_b}, vga_blank_n, p_exp[i]);
      end
    end
    set_rect(0, 0, HT - 1, 0, VT - 1, 8'hFF);
    repeat (3) @(posedge clk);
    wait_xy(20, 3);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({vga_r, vga_g, vga_b, vga_hsync_n, vga_vsync_n, vga_blank_n} !== {24'h0, 3'b010}) begin
      n_fail++;
      $display("FAIL hblank_pixel: got rgb=%h hs/vs/blank=%b want 000000 010",
               {vga_r, vga_g, vga_b}, {vga_hsync_n, vga_vsync_n, vga_blank_n});
    end
  endtask

  task automatic test_overlap();
    clear_rects();
    wait_fs();
    set_rect(0, 2, 5, 3, 6, 8'hE0);
    set_rect(2, 4, 8, 5, 9, 8'h1C);
    wait_fs();
    @(posedge clk); #1;
    n_tests++; if (frame_overlap !== 4'b0100) begin n_fail++; $display("FAIL overlap_rects: got %b want 0100", frame_overlap); end
    wait_xy(8, 6);
    n_tests++; if (frame_overlap !== 4'b0100) begin n_fail++; $display("FAIL overlap_stable: got %b want 0100", frame_overlap); end
    wait_fs();
    set_rect(2, 10, 12, 8, 9, 8'h1C);
    wait_fs();
    @(posedge clk); #1;
    n_tests++; if (frame_overlap !== 4'b0000) begin n_fail++; $display("FAIL overlap_none: got %b want 0000", frame_overlap); end
  endtask

  task automatic test_overlap_all();
    clear_rects();
    wait_fs();
    set_rect(0, 0, HT - 1, 0, VT - 1, 8'h11);
    set_rect(1, 0, HT - 1, 0, VT - 1, 8'h22);
    set_rect(3, 0, HT - 1, 0, VT - 1, 8'h33);
    wait_fs();
    @(posedge clk); #1;
    n_tests++; if (frame_overlap !== 4'b1010) begin n_fail++; $display("FAIL overlap_multi: got %b want 1010", frame_overlap); end
  endtask

  task automatic test_mid_reset();
    int n = 0, err_ov = 0;
    bit found = 1'b0;
    wait_xy(8, 6);
    resetN = 1'b0;
    #1;
    n_tests++; if ({bus.requested_x, bus.requested_y} !== 22'd0) begin n_fail++; $display("FAIL mid_reset_xy: got (%0d,%0d) want (0,0)", bus.requested_x, bus.requested_y); end
    n_tests++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin n_fail++; $display("FAIL mid_reset_rgb: got %h want 000000", {vga_r, vga_g, vga_b}); end
    n_tests++; if ({vga_hsync_n, vga_vsync_n, vga_blank_n} !== 3'b110) begin n_fail++; $display("FAIL mid_reset_sync: got %b want 110", {vga_hsync_n, vga_vsync_n, vga_blank_n}); end
    n_tests++; if (frame_overlap !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_overlap: got %b want 0000", frame_overlap); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (bus.requested_x !== 11'd0) begin n_fail++; $display("FAIL reset_hold_x: got %0d want 0", bus.requested_x); end
    resetN = 1'b1;
    for (int i = 1; i <= 2 * FRAME && !found; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        n_tests++;
        if ({bus.requested_x, bus.requested_y} !== {11'd1, 11'd0}) begin
          n_fail++; $display("FAIL restart_xy: got (%0d,%0d) want (1,0)", bus.requested_x, bus.requested_y);
        end
      end
      if (frame_overlap !== 4'b0000) err_ov++;
      if (bus.frame_start === 1'b1) begin found = 1'b1; n = i; end
    end
    n_tests++; if (n != V_ACT * HT) begin n_fail++; $display("FAIL restart_fs: got %0d cycles want %0d", n, V_ACT * HT); end
    n_tests++; if (err_ov != 0) begin n_fail++; $display("FAIL restart_overlap_hold: %0d cycles nonzero, want 0", err_ov); end
    @(posedge clk); #1;
    n_tests++; if (frame_overlap !== 4'b1010) begin n_fail++; $display("FAIL restart_overlap: got %b want 1010", frame_overlap); end
  endtask

  task automatic test_blanking();
    clear_rects();
    wait_fs();
    set_rect(0, 20, 20, 0, VT - 1, 8'hFF);
    set_rect(1, 20, 20, 0, VT - 1, 8'hE0);
    wait_xy(20, 4);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({vga_r, vga_g, vga_b, vga_blank_n} !== 25'h0) begin
      n_fail++; $display("FAIL blank_ignore_rgb: got rgb=%h blank=%b want 000000 0", {vga_r, vga_g, vga_b}, vga_blank_n);
    end
    wait_fs();
    @(posedge clk); #1;
    n_tests++; if (frame_overlap !== 4'b0000) begin n_fail++; $display("FAIL blank_ignore_overlap: got %b want 0000", frame_overlap); end
  endtask

  initial begin
    clear_rects();
    test_reset();
    test_raster();
    test_priority();
    test_overlap();
    test_overlap_all();
    test_mid_reset();
    test_blanking();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
